// File: rtl/main_mem_responder_pkg.sv
// Shared cache/memory interface types and the responder FSM encoding.
package cache_def;

  // Request from the cache controller to main memory.
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  // Response from main memory back to the cache controller.
  typedef struct packed {
    logic [127:0] data;
    logic         ready;
    logic         valid;
  } mem_data_type;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } mem_resp_state_type;

  // Default request-to-response latency in clock cycles.
  localparam int MEM_LATENCY = 4;

endpackage

// File: rtl/mem_line_ram.sv
// Line storage for the main memory model: 2^DEPTH_LOG2 lines of 128 bits.
// Contents are deliberately not reset so that data survives a controller reset.
module mem_line_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [127:0]          wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [127:0]          rd_data
);

  logic [127:0] lines [2**DEPTH_LOG2];

  // Commit a full line on the clock edge when the write port is enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lines[wr_idx] <= wr_data;
    end
  end

  assign rd_data = lines[rd_idx];

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main memory responder: accepts one request in IDLE, waits
// LATENCY cycles, then answers with a one-cycle ready pulse. Reads return the
// stored line; writes commit the latched line on the edge that ends RESPOND.
module main_mem_responder
  import cache_def::*;
#(
  parameter int LATENCY    = MEM_LATENCY,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy
);

  mem_resp_state_type state;
  mem_resp_state_type next_state;
  logic [7:0]         count;
  logic [7:0]         next_count;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [127:0]          req_data;
  logic                  req_rw;
  logic [127:0]          read_data;
  logic [127:0]          line_rd_data;
  logic                  line_wr_en;
  logic                  accept;
  logic                  unused_addr_bits;

  // Byte offset and upper address bits do not select a line; they alias.
  assign unused_addr_bits = ^{mem_req.addr[31:DEPTH_LOG2+4], mem_req.addr[3:0]};

  assign accept     = (state == IDLE) && mem_req.valid;
  assign line_wr_en = (state == RESPOND) && req_rw;

  // State, countdown and the latched request; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 8'd0;
      req_idx  <= '0;
      req_data <= '0;
      req_rw   <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (accept) begin
        req_idx  <= mem_req.addr[DEPTH_LOG2+3:4];
        req_data <= mem_req.data;
        req_rw   <= mem_req.rw;
      end
    end
  end

  // Next-state logic: the counter reaching zero in BUSY lands RESPOND exactly
  // LATENCY cycles after acceptance.
  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      IDLE: begin
        if (mem_req.valid) begin
          next_state = BUSY;
          next_count = 8'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (count == 8'd0) begin
          next_state = RESPOND;
        end else begin
          next_count = count - 8'd1;
        end
      end
      RESPOND: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_count = 8'd0;
      end
    endcase
  end

  // Capture read data as RESPOND is entered; it then holds until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if ((state == BUSY) && (count == 8'd0) && !req_rw) begin
      read_data <= line_rd_data;
    end
  end

  // Drive the response bundle; ready and valid only ever pulse in RESPOND.
  always_comb begin
    mem_data       = '0;
    mem_data.data  = read_data;
    mem_data.ready = (state == RESPOND);
    mem_data.valid = (state == RESPOND) && !req_rw;
  end

  assign busy = (state != IDLE);

  mem_line_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_lines (
    .clk     (clk),
    .wr_en   (line_wr_en),
    .wr_idx  (req_idx),
    .wr_data (req_data),
    .rd_idx  (req_idx),
    .rd_data (line_rd_data)
  );

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: default-latency DUT plus a LATENCY=1 build.
module tb_main_mem_responder;
  import cache_def::*;

  logic         clk;
  logic         rst;
  mem_req_type  req;
  mem_req_type  req1;
  mem_data_type rsp;
  mem_data_type rsp1;
  logic         busy;
  logic         busy1;

  int errors;
  int checks;

  localparam logic [127:0] W1 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] B3 = 128'h33333333_44444444_55555555_66666666;
  localparam logic [127:0] C7 = 128'h77777777_77777777_77777777_77777777;
  localparam logic [127:0] E9 = 128'h99990000_11112222_33334444_55556666;

  main_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (req),
    .mem_data (rsp),
    .busy     (busy)
  );

  main_mem_responder #(.LATENCY(1)) dut_l1 (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (req1),
    .mem_data (rsp1),
    .busy     (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request on the chosen DUT and return just after the accepting edge.
  task automatic applyStimulus(input bit sel_l1, input logic [31:0] a,
                               input logic [127:0] d, input logic rw);
    @(negedge clk);
    if (sel_l1) begin
      req1.addr = a; req1.data = d; req1.rw = rw; req1.valid = 1'b1;
    end else begin
      req.addr = a; req.data = d; req.rw = rw; req.valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rsp.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 0", rsp.ready); end
    checks++; if (rsp.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", rsp.valid); end
    checks++; if (rsp.data !== 128'd0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", rsp.data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read_latency();
    applyStimulus(1'b0, 32'h0000_0040, 128'd0, 1'b0);
    req.valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rd_busy_c0: got %0b expected 1", busy); end
    for (int k = 1; k < 4; k++) begin
      step(1);
      checks++; if (rsp.ready !== 1'b0) begin errors++; $display("[TB] FAIL rd_early_ready_c%0d: got %0b expected 0", k, rsp.ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rd_busy_c%0d: got %0b expected 1", k, busy); end
    end
    step(1);
    checks++; if (rsp.ready !== 1'b1) begin errors++; $display("[TB] FAIL rd_ready: got %0b expected 1", rsp.ready); end
    checks++; if (rsp.valid !== 1'b1) begin errors++; $display("[TB] FAIL rd_valid: got %0b expected 1", rsp.valid); end
    checks++; if (rsp.data !== 128'd0) begin errors++; $display("[TB] FAIL rd_data: got %0h expected 0", rsp.data); end
    step(1);
    checks++; if (rsp.ready !== 1'b0) begin errors++; $display("[TB] FAIL rd_ready_drop: got %0b expected 0", rsp.ready); end
    checks++; if (rsp.valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_valid_drop: got %0b expected 0", rsp.valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rd_busy_drop: got %0b expected 0", busy); end
  endtask

  task automatic test_write_then_read();
    applyStimulus(1'b0, 32'h0000_1230, W1, 1'b1);
    req.valid = 1'b0;
    step(4);
    checks++; if (rsp.ready !== 1'b1) begin errors++; $display("[TB] FAIL wr_ready: got %0b expected 1", rsp.ready); end
    checks++; if (rsp.valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_valid: got %0b expected 0", rsp.valid); end
    checks++; if (rsp.data !== 128'd0) begin errors++; $display("[TB] FAIL wr_data_hold: got %0h expected 0", rsp.data); end
    step(1);
    applyStimulus(1'b0, 32'h0000_123C, 128'd0, 1'b0);
    req.valid = 1'b0;
    step(4);
    checks++; if (rsp.valid !== 1'b1) begin errors++; $display("[TB] FAIL raw_valid: got %0b expected 1", rsp.valid); end
    checks++; if (rsp.data !== W1) begin errors++; $display("[TB] FAIL raw_data: got %0h expected %0h", rsp.data, W1); end
    step(1);
  endtask

  task automatic test_alias();
    applyStimulus(1'b0, 32'h0000_4010, A5, 1'b1);
    req.valid = 1'b0;
    step(4);
    checks++; if (rsp.data !== W1) begin errors++; $display("[TB] FAIL alias_wr_hold: got %0h expected %0h", rsp.data, W1); end
    step(1);
    applyStimulus(1'b0, 32'h0000_0010, 128'd0, 1'b0);
    req.valid = 1'b0;
    step(4);
    checks++; if (rsp.data !== A5) begin errors++; $display("[TB] FAIL alias_rd_data: got %0h expected %0h", rsp.data, A5); end
    step(1);
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 32'h0000_0030, B3, 1'b1);
    step(4);
    checks++; if (rsp.ready !== 1'b1 || rsp.valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wr_resp: got ready=%0b valid=%0b expected ready=1 valid=0", rsp.ready, rsp.valid); end
    req.addr = 32'h0000_0030; req.data = 128'd0; req.rw = 1'b0; req.valid = 1'b1;
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %0b expected 0", busy); end
    step(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: got %0b expected 1", busy); end
    req.valid = 1'b0;
    step(3);
    checks++; if (rsp.ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_early_ready: got %0b expected 0", rsp.ready); end
    step(1);
    checks++; if (rsp.ready !== 1'b1 || rsp.valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rd_resp: got ready=%0b valid=%0b expected 1/1", rsp.ready, rsp.valid); end
    checks++; if (rsp.data !== B3) begin errors++; $display("[TB] FAIL b2b_rd_data: got %0h expected %0h", rsp.data, B3); end
    step(1);
  endtask

  task automatic test_ignore_while_busy();
    applyStimulus(1'b0, 32'h0000_1230, 128'd0, 1'b0);
    req.addr = 32'h0000_0010; req.data = C7; req.rw = 1'b1; req.valid = 1'b1;
    step(3);
    req.valid = 1'b0;
    step(1);
    checks++; if (rsp.valid !== 1'b1) begin errors++; $display("[TB] FAIL ign_valid: got %0b expected 1", rsp.valid); end
    checks++; if (rsp.data !== W1) begin errors++; $display("[TB] FAIL ign_data: got %0h expected %0h", rsp.data, W1); end
    step(1);
    applyStimulus(1'b0, 32'h0000_0010, 128'd0, 1'b0);
    req.valid = 1'b0;
    step(4);
    checks++; if (rsp.data !== A5) begin errors++; $display("[TB] FAIL ign_no_write: got %0h expected %0h", rsp.data, A5); end
    step(1);
  endtask

  task automatic test_reset_mid_write();
    applyStimulus(1'b0, 32'h0000_0010, C7, 1'b1);
    req.valid = 1'b0;
    step(2);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmw_busy: got %0b expected 0", busy); end
    checks++; if (rsp.ready !== 1'b0 || rsp.valid !== 1'b0) begin errors++; $display("[TB] FAIL rmw_flags: got ready=%0b valid=%0b expected 0/0", rsp.ready, rsp.valid); end
    checks++; if (rsp.data !== 128'd0) begin errors++; $display("[TB] FAIL rmw_data: got %0h expected 0", rsp.data); end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0000_0010, 128'd0, 1'b0);
    req.valid = 1'b0;
    step(4);
    checks++; if (rsp.data !== A5) begin errors++; $display("[TB] FAIL rmw_old_data: got %0h expected %0h", rsp.data, A5); end
    step(1);
  endtask

  task automatic test_latency_one();
    applyStimulus(1'b1, 32'h0000_0020, E9, 1'b1);
    req1.valid = 1'b0;
    checks++; if (busy1 !== 1'b1 || rsp1.ready !== 1'b0) begin errors++; $display("[TB] FAIL l1_accept: got busy=%0b ready=%0b expected 1/0", busy1, rsp1.ready); end
    step(1);
    checks++; if (rsp1.ready !== 1'b1 || rsp1.valid !== 1'b0) begin errors++; $display("[TB] FAIL l1_wr_resp: got ready=%0b valid=%0b expected 1/0", rsp1.ready, rsp1.valid); end
    step(1);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL l1_idle: got %0b expected 0", busy1); end
    applyStimulus(1'b1, 32'h0000_0020, 128'd0, 1'b0);
    req1.valid = 1'b0;
    step(1);
    checks++; if (rsp1.ready !== 1'b1 || rsp1.valid !== 1'b1) begin errors++; $display("[TB] FAIL l1_rd_resp: got ready=%0b valid=%0b expected 1/1", rsp1.ready, rsp1.valid); end
    checks++; if (rsp1.data !== E9) begin errors++; $display("[TB] FAIL l1_rd_data: got %0h expected %0h", rsp1.data, E9); end
    step(1);
    checks++; if (rsp1.ready !== 1'b0) begin errors++; $display("[TB] FAIL l1_ready_drop: got %0b expected 0", rsp1.ready); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    req    = '0;
    req1   = '0;
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_alias();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_write();
    test_latency_one();
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
